// File: rtl/level_select_ctrl.sv
// Level picker: synchronises and debounces the level buttons, accepts a stable
// one-hot press as the selected level, then locks until the game ends.
module level_select_ctrl #(
  parameter int NUM_LEVELS      = 4,
  parameter int LEVEL_W         = 2,
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_LEVELS-1:0] level_buttons,
  input  logic                  game_over,
  output logic [LEVEL_W-1:0]    level,
  output logic                  start,
  output logic                  active,
  output logic                  invalid_press
);
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int POP_W = $clog2(NUM_LEVELS + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);

  typedef enum logic [1:0] {WAIT_RELEASE, ARMED, PLAYING} state_t;

  state_t                state;
  logic [NUM_LEVELS-1:0] sync1, sync2;
  logic [CNT_W-1:0]      cnt;
  logic                  stable;
  logic [POP_W-1:0]      ones;
  logic [LEVEL_W-1:0]    enc;
  logic                  one_hot, multi;

  // The counter clears on the edge that loads a new value into sync2, so it
  // restarts in the same cycle the debounced view of the buttons changes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
      cnt   <= '0;
    end else begin
      sync1 <= level_buttons;
      sync2 <= sync1;
      if (sync1 != sync2)
        cnt <= '0;
      else if (cnt != CNT_MAX)
        cnt <= cnt + CNT_W'(1);
    end
  end

  assign stable = (cnt == CNT_MAX);

  always_comb begin
    ones = '0;
    enc  = '0;
    for (int i = 0; i < NUM_LEVELS; i++) begin
      if (sync2[i]) begin
        ones = ones + POP_W'(1);
        enc  = LEVEL_W'(i);
      end
    end
    one_hot = (ones == POP_W'(1));
    multi   = (ones > POP_W'(1));
  end

  assign invalid_press = (state == ARMED) && stable && multi;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= WAIT_RELEASE;
      level  <= '0;
      start  <= 1'b0;
      active <= 1'b0;
    end else begin
      start <= 1'b0;
      case (state)
        WAIT_RELEASE: if (stable && (sync2 == '0)) state <= ARMED;
        ARMED: begin
          if (stable && one_hot) begin
            level  <= enc;
            start  <= 1'b1;
            active <= 1'b1;
            state  <= PLAYING;
          end
        end
        PLAYING: begin
          if (game_over) begin
            active <= 1'b0;
            state  <= WAIT_RELEASE;
          end
        end
        default: state <= WAIT_RELEASE;
      endcase
    end
  end
endmodule

// File: tb/tb_level_select_ctrl.sv
// Scoreboard bench for level_select_ctrl: accepted presses queue their level
// and start cycle; the monitor pops and checks on every start pulse.
module tb_level_select_ctrl;
  localparam int NL = 4;
  localparam int LW = 2;
  localparam int DB = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          game_over = 1'b0;
  logic [NL-1:0] btn = '0;
  logic [LW-1:0] level;
  logic          start, active, invalid_press;

  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;
  logic prev_start = 1'b0;

  typedef struct {
    logic [LW-1:0] lvl;
    int            cyc;
  } exp_t;
  exp_t sb[$];
  exp_t mon_e;

  level_select_ctrl #(.NUM_LEVELS(NL), .LEVEL_W(LW), .DEBOUNCE_CYCLES(DB)) dut (
    .clk(clk), .reset(reset), .level_buttons(btn), .game_over(game_over),
    .level(level), .start(start), .active(active), .invalid_press(invalid_press)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cyc %0d)", tag, got, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (start) begin
      chk("start_width", 32'(prev_start), 32'(0));
      chk("start_expected", 32'(sb.size() != 0), 32'(1));
      if (sb.size() != 0) begin
        mon_e = sb.pop_front();
        chk("start_cyc", 32'(cyc), 32'(mon_e.cyc));
        chk("start_level", 32'(level), 32'(mon_e.lvl));
      end
    end
    prev_start = start;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drive a press expected to be accepted; start is due DB+3 edges later.
  task automatic press(input logic [NL-1:0] v, input logic [LW-1:0] lvl);
    exp_t e;
    btn   = v;
    e.lvl = lvl;
    e.cyc = cyc + DB + 3;
    sb.push_back(e);
  endtask

  // Check invalid_press on n negedges; expected high for negedges from..to.
  task automatic watch_inv(input int n, input int from, input int to);
    for (int i = 1; i <= n; i++) begin
      @(negedge clk);
      chk("invalid_press", 32'(invalid_press), 32'((i >= from) && (i <= to)));
    end
  endtask

  task automatic end_game();
    game_over = 1'b1;
    tick(1);
    game_over = 1'b0;
    @(negedge clk);
    chk("go_active", 32'(active), 32'(0));
    tick(1);
  endtask

  initial begin
    tick(2);
    @(negedge clk);
    chk("rst_level", 32'(level), 32'(0));
    chk("rst_start", 32'(start), 32'(0));
    chk("rst_active", 32'(active), 32'(0));
    chk("rst_invalid", 32'(invalid_press), 32'(0));
    tick(1);
    reset = 1'b0;
    tick(8);

    // short glitch never reaches stability
    btn = 4'b0010;
    tick(3);
    btn = '0;
    watch_inv(10, 1, 0);
    chk("glitch_level", 32'(level), 32'(0));
    chk("glitch_active", 32'(active), 32'(0));
    tick(1);

    // clean single press
    press(4'b0100, 2'd2);
    watch_inv(9, 1, 0);
    chk("t1_active", 32'(active), 32'(1));
    chk("t1_level", 32'(level), 32'(2));
    tick(1);
    btn = '0;
    tick(3);

    // buttons ignored while playing; held button blocks restart
    btn = 4'b1000;
    tick(10);
    chk("play_level", 32'(level), 32'(2));
    chk("play_active", 32'(active), 32'(1));
    end_game();
    tick(10);
    chk("held_active", 32'(active), 32'(0));
    btn = '0;
    tick(6);
    press(4'b1000, 2'd3);
    watch_inv(9, 1, 0);
    chk("t4_active", 32'(active), 32'(1));
    chk("t4_level", 32'(level), 32'(3));
    tick(1);
    end_game();
    btn = '0;
    tick(8);

    // multi-button press is invalid until the vector changes
    btn = 4'b0011;
    watch_inv(11, 7, 11);
    tick(1);
    press(4'b0010, 2'd1);
    watch_inv(9, 1, 2);
    chk("t3_active", 32'(active), 32'(1));
    chk("t3_level", 32'(level), 32'(1));
    tick(1);
    end_game();
    btn = '0;
    tick(8);

    // async reset mid-debounce, button held through reset release
    btn = 4'b0001;
    tick(4);
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_level", 32'(level), 32'(0));
    chk("mid_rst_start", 32'(start), 32'(0));
    chk("mid_rst_active", 32'(active), 32'(0));
    chk("mid_rst_invalid", 32'(invalid_press), 32'(0));
    tick(3);
    reset = 1'b0;
    tick(12);
    chk("held_rst_active", 32'(active), 32'(0));
    btn = '0;
    tick(8);
    press(4'b0001, 2'd0);
    watch_inv(9, 1, 0);
    chk("t5_active", 32'(active), 32'(1));
    chk("t5_level", 32'(level), 32'(0));
    tick(1);
    end_game();
    btn = '0;
    tick(8);

    // game_over in the menu is ignored
    game_over = 1'b1;
    tick(1);
    game_over = 1'b0;
    @(negedge clk);
    chk("armed_go_active", 32'(active), 32'(0));
    tick(1);
    press(4'b0001, 2'd0);
    watch_inv(9, 1, 0);
    chk("t6_active", 32'(active), 32'(1));
    chk("t6_level", 32'(level), 32'(0));
    tick(1);
    end_game();
    btn = '0;
    tick(2);

    chk("sb_empty", 32'(sb.size()), 32'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/level_select_ctrl.md
Name: level_select_ctrl

Overview:
- Parametrised successor of the home-screen level picker. Takes a raw vector of NUM_LEVELS level buttons, then synchronises, debounces and validates the vector as one-hot.
- On a valid press it latches the encoded level and issues a one-cycle start pulse.
- It then locks until the game reports game_over. Unlike the previous picker, it returns to the menu without a system reset.
- Sits between the board push-buttons and the game FSM / VGA menu renderer.

Parameters:
- NUM_LEVELS, 4, number of level buttons (2..16).
- LEVEL_W, 2, width of level output; must equal max(1, clog2(NUM_LEVELS)).
- DEBOUNCE_CYCLES, 1000000, consecutive clocks the synchronised button vector must hold unchanged to be accepted (>=1; 10 ms at 100 MHz).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- level_buttons  in  NUM_LEVELS  raw async button inputs; bit i selects level i.
- game_over  in  1  one-cycle pulse from game FSM; ends the current game.
- level  out  LEVEL_W  selected level, binary encoded.
- start  out  1  one-cycle pulse when a level is accepted.
- active  out  1  high while a game is in progress.
- invalid_press  out  1  high while a stable multi-button vector is present in the menu.

Behaviour:
- Reset is asynchronous and active-high; clk is the only clock.
- Reset values:
  - level=0, start=0, active=0, invalid_press=0.
  - Synchroniser flops=0, debounce counter=0.
  - State=WAIT_RELEASE.
- Synchroniser: 2-flop per bit; the debouncer sees only sync output.
- Debouncer:
  - Counter clears on any cycle where the sync vector differs from the previous sync vector; otherwise it increments, saturating at DEBOUNCE_CYCLES.
  - "stable" = counter==DEBOUNCE_CYCLES.
  - The stable vector is the sync vector while stable.
- States:
  - WAIT_RELEASE: go to ARMED when stable and vector==0.
  - ARMED: if stable and the vector is exactly one-hot with bit i set: level<=i, start<=1 for one cycle, go to PLAYING. If stable and popcount>=2: invalid_press=1, stay. Stable zero: stay.
  - PLAYING: active=1; all buttons ignored; level held. On game_over: go to WAIT_RELEASE, active<=0 on the next edge.
- Latency: a button vector applied before edge k and held produces start high in the cycle after edge k+DEBOUNCE_CYCLES+2. That is exactly DEBOUNCE_CYCLES+3 edges, inclusive of the start-register edge.
- start is never high for more than one cycle and never re-asserts in PLAYING.
- invalid_press:
  - Combinational from state and debouncer.
  - Drops as soon as the vector changes (counter cleared).
  - Only asserted in ARMED.
- Glitch shorter than DEBOUNCE_CYCLES: counter clears; no start.
- The one-hot vector is sampled only at stability, so press order does not matter. A press overlapping a second button yields invalid, not the first level.
- Held button at game_over: WAIT_RELEASE blocks restart until all buttons are released and stable.
- game_over outside PLAYING: ignored.
- Reset mid-debounce or mid-game: all state returns to reset values immediately. A button still held after reset deassertion must be released before any start.
- level retains its last accepted value across game_over. It changes only on accept or reset.

Test Plan:
- Common bench setting: NUM_LEVELS=4, DEBOUNCE_CYCLES=4.
- Reset release, buttons=0 for 8 cycles, then buttons=4'b0100 held -> start high for exactly one cycle, 7 edges after apply; level=2; active=1 next cycle; invalid_press=0 throughout.
- In ARMED, buttons=4'b0010 for 3 cycles then 0 -> no start, level stays 0, state stays ARMED.
- buttons=4'b0011 held 10 cycles -> invalid_press=1 from the debounced point until the vector changes; no start. Then release bit0 to 4'b0010 -> start after 7 edges, level=1.
- In PLAYING, press 4'b1000 -> no start, level unchanged. Pulse game_over while 4'b1000 is still held -> active=0, no start. Release, wait 6 cycles, press 4'b1000 -> start, level=3.
- Assert reset asynchronously mid-debounce of 4'b0001 (counter=2) -> outputs 0 within the same cycle. Keep the button held after reset release -> no start until it is released and re-pressed.
- game_over pulse while in ARMED -> ignored. Subsequent 4'b0001 press -> start, level=0.
